// File: rtl/mvm_stream_feeder.sv
// mvm_stream_feeder: buffers one NxN matrix-vector problem, streams it to the accelerator, collects results
module mvm_stream_feeder #(
    parameter int N = 3,
    parameter int IW = 8,
    parameter int OW = 16,
    localparam int TOTAL = N*N+2*N,
    localparam int AW = $clog2(TOTAL),
    localparam int RW = $clog2(N),
    localparam int CW = $clog2(N+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [IW-1:0] cfg_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    output logic [IW-1:0] out_data,
    input  logic          out_ready,
    input  logic          in_valid,
    input  logic [OW-1:0] in_data,
    output logic          in_ready,
    input  logic          in_ready_en,
    input  logic [RW-1:0] res_addr,
    output logic [OW-1:0] res_data,
    output logic [15:0]   cycle_count
);
    typedef enum logic [1:0] {IDLE, SEND, COLLECT, DONE} state_t;
    localparam logic [AW-1:0] LAST = AW'(TOTAL-1);
    localparam logic [CW-1:0] NC = CW'(N);
    localparam logic [CW-1:0] NM1 = CW'(N-1);
    state_t state, state_next;
    logic [AW-1:0] tx_idx;
    logic [CW-1:0] rx_cnt;
    logic [IW-1:0] buf_q [TOTAL];
    logic [OW-1:0] result [N];
    logic tx_fire, rx_fire, tx_last, rx_full_next;
    assign busy = state == SEND || state == COLLECT;
    assign done = state == DONE;
    assign out_valid = state == SEND;
    assign out_data = buf_q[tx_idx];
    assign in_ready = busy && rx_cnt < NC && in_ready_en;
    assign tx_fire = out_valid && out_ready;
    assign rx_fire = in_valid && in_ready;
    assign tx_last = tx_fire && tx_idx == LAST;
    assign rx_full_next = rx_cnt == NC || (rx_fire && rx_cnt == NM1);
    assign res_data = int'(res_addr) < N ? result[res_addr] : '0;
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_next;
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = start ? SEND : IDLE;
            SEND:    state_next = tx_last ? (rx_full_next ? DONE : COLLECT) : SEND;
            COLLECT: state_next = rx_full_next ? DONE : COLLECT;
            DONE:    state_next = IDLE;
        endcase
    end
    // tx_idx wraps after the final word so it never addresses past the buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_idx <= '0;
            rx_cnt <= '0;
            cycle_count <= '0;
            for (int i = 0; i < N; i++) result[i] <= '0;
        end else if (state == IDLE && start) begin
            tx_idx <= '0;
            rx_cnt <= '0;
            cycle_count <= '0;
        end else begin
            if (tx_fire) tx_idx <= tx_last ? '0 : tx_idx + 1'b1;
            if (rx_fire) begin
                result[rx_cnt] <= in_data;
                rx_cnt <= rx_cnt + 1'b1;
            end
            if (busy && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (cfg_we && !busy && int'(cfg_addr) < TOTAL) buf_q[cfg_addr] <= cfg_data;
endmodule

// File: tb/tb_mvm_stream_feeder.sv
// tb_mvm_stream_feeder: directed checks of streaming, capture, throttling and abuse cases
module tb_mvm_stream_feeder;
    logic clk = 0, reset = 1, cfg_we = 0, start = 0, out_ready = 1, in_valid = 0, in_ready_en = 1;
    logic [3:0] cfg_addr = 0;
    logic [7:0] cfg_data = 0;
    logic [15:0] in_data = 0;
    logic [1:0] res_addr = 0;
    logic busy, done, out_valid, in_ready;
    logic [7:0] out_data;
    logic [15:0] res_data, cycle_count;
    int tests = 0, fails = 0;
    int nsent, nres, stall_bad, throttle_bad, done_nres;
    logic done_busy;
    logic [7:0] sent [32];
    logic [7:0] exp_s [15];
    logic [15:0] res_in [3];

    mvm_stream_feeder dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .busy(busy), .done(done), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .in_ready_en(in_ready_en), .res_addr(res_addr), .res_data(res_data), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_buf();
        cfg_we = 1;
        for (int i = 0; i < 15; i++) begin
            cfg_addr = 4'(i);
            cfg_data = exp_s[i];
            clk1();
        end
        cfg_addr = 4'd15;
        cfg_data = 8'hAA;
        clk1();
        cfg_we = 0;
    endtask

    task automatic run(input int rdy_pat, input int hold, input bit abuse, input int rst_at);
        int vcyc;
        bit stalled;
        logic [7:0] prev;
        nsent = 0; nres = 0; stall_bad = 0; throttle_bad = 0; done_nres = -1; done_busy = 1'bx;
        vcyc = 0; stalled = 0; prev = 0;
        start = 1;
        clk1();
        start = 0;
        for (int c = 0; c < 300; c++) begin
            out_ready = rdy_pat == 0 ? 1'b1 : (c % 2 == 0);
            start = abuse && c == 5;
            cfg_we = abuse && nsent == 15 && nres == 1;
            cfg_addr = 0;
            cfg_data = 8'h55;
            in_valid = nsent == 15 && nres < 3;
            in_data = res_in[nres < 3 ? nres : 0];
            in_ready_en = !(in_valid && vcyc < hold);
            #1;
            if (out_valid && stalled && out_data !== prev) stall_bad++;
            stalled = out_valid && !out_ready;
            prev = out_data;
            if (in_valid && !in_ready_en && in_ready !== 1'b0) throttle_bad++;
            if (done) begin
                done_nres = nres;
                done_busy = busy;
                break;
            end
            if (out_valid && out_ready) begin
                sent[nsent] = out_data;
                nsent++;
            end
            if (in_valid) vcyc++;
            if (in_valid && in_ready) nres++;
            if (rst_at >= 0 && nsent == rst_at) begin
                clk1();
                break;
            end
            clk1();
        end
        start = 0; cfg_we = 0; in_valid = 0; out_ready = 1; in_ready_en = 1;
    endtask

    task automatic chk_done(input logic [15:0] exp_cycles);
        chk("done_after_n", done_nres, 3);
        chk("busy_at_done", done_busy, 0);
        clk1();
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
        chk("cycles", cycle_count, exp_cycles);
    endtask

    task automatic chk_stream();
        chk("stream_len", nsent, 15);
        for (int i = 0; i < 15; i++) chk($sformatf("stream[%0d]", i), sent[i], exp_s[i]);
    endtask

    task automatic chk_res();
        for (int a = 0; a < 3; a++) begin
            res_addr = 2'(a);
            #1;
            chk($sformatf("res[%0d]", a), res_data, res_in[a]);
        end
    endtask

    initial begin
        clk1();
        clk1();
        reset = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_res", res_data, 0);

        exp_s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
                  8'h01, 8'h02, 8'h03, 8'h0A, 8'h14, 8'h1E};
        res_in = '{16'd11, 16'd22, 16'd33};
        load_buf();
        run(0, 0, 0, -1);
        chk_done(16'd18);
        chk_stream();
        chk_res();
        res_addr = 2'd3;
        #1;
        chk("res_oob", res_data, 0);

        exp_s = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                  8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        res_in = '{16'hFFFA, 16'hFFFA, 16'hFFFA};
        load_buf();
        run(0, 0, 0, -1);
        chk_done(16'd18);
        chk_stream();
        chk_res();

        exp_s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
                  8'h01, 8'h02, 8'h03, 8'h0A, 8'h14, 8'h1E};
        res_in = '{16'd11, 16'd22, 16'd33};
        load_buf();
        run(1, 0, 0, -1);
        chk_done(16'd32);
        chk("stall_stable", stall_bad, 0);
        chk_stream();
        chk_res();

        res_in = '{16'h0101, 16'h8000, 16'h7FFF};
        run(0, 5, 0, -1);
        chk_done(16'd23);
        chk("throttle_in_ready", throttle_bad, 0);
        chk_res();

        res_in = '{16'd11, 16'd22, 16'd33};
        run(0, 0, 1, -1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1;
            in_data = 16'h7777;
            #1;
            chk("extra_in_ready", in_ready, 0);
            clk1();
        end
        in_valid = 0;
        chk("abuse_stream_len", nsent, 15);
        chk("abuse_done_n", done_nres, 3);
        chk("abuse_cycles", cycle_count, 18);
        chk_res();
        res_in = '{16'hFFF0, 16'h0010, 16'h1234};
        run(0, 0, 0, -1);
        chk_done(16'd18);
        chk_stream();
        chk_res();

        run(0, 0, 0, 7);
        chk("pre_rst_sent", nsent, 7);
        reset = 1;
        clk1();
        reset = 0;
        res_addr = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cycles", cycle_count, 0);
        chk("mid_rst_res", res_data, 0);
        res_in = '{16'd11, 16'd22, 16'd33};
        run(0, 0, 0, -1);
        chk_done(16'd18);
        chk_stream();
        chk_res();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mvm_stream_feeder.md
Name: mvm_stream_feeder

Overview:
Host-side driver for the 3x3 matrix-vector accelerator's byte-stream interface. It holds one problem (W matrix, bias b, vector x) in a local buffer loaded over a simple write port. On start it streams the problem to the accelerator over a valid/ready byte channel, then collects the signed 16-bit result words from the accelerator's output channel. It exposes the results, a done pulse and a cycle count to the host, and is the standard stimulus/collection front-end for accelerator bring-up.

Parameters:
N, 3, matrix dimension (W is NxN; b, x, y have N entries)
IW, 8, stream input word width (W/b/x element width)
OW, 16, result word width
TOTAL, N*N+2*N, words streamed per problem (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  buffer write enable
cfg_addr  in  $clog2(TOTAL)  buffer index; 0..N*N-1 W row-major, then b[0..N-1], then x[0..N-1]
cfg_data  in  IW  buffer write data
start  in  1  single-cycle request to run the loaded problem
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when all N results are captured
out_valid  out  1  to accelerator s_valid
out_data  out  IW  to accelerator data_in
out_ready  in  1  from accelerator s_ready
in_valid  in  1  from accelerator m_valid
in_data  in  OW  from accelerator data_out, signed
in_ready  out  1  to accelerator m_ready
in_ready_en  in  1  host/bench throttle; in_ready forced low when 0
res_addr  in  $clog2(N)  result select
res_data  out  OW  result[res_addr], combinational read
cycle_count  out  16  cycles from accepted start to done, saturating

Behaviour:
- Reset: state=IDLE, busy=0, done=0, out_valid=0, in_ready=0, tx_idx=0, rx_cnt=0, cycle_count=0, all result registers=0. Problem buffer is not reset.
- States: IDLE, SEND, COLLECT, DONE.
- IDLE: start=1 -> SEND next cycle. Same edge: tx_idx=0, rx_cnt=0, cycle_count=0. Result registers are not cleared.
- SEND: out_valid=1; out_data=buf[tx_idx].
  - Transfer occurs on a cycle with out_valid && out_ready; then tx_idx increments.
  - While out_ready=0, out_data and out_valid hold stable.
  - Transfer of index TOTAL-1: next state COLLECT, or DONE if rx_cnt has already reached N on the same edge.
  - out_valid drops the cycle after the final transfer. No gap cycles between consecutive transfers when out_ready stays high, so TOTAL words take TOTAL cycles minimum.
- Result capture: in_ready = busy && (rx_cnt<N) && in_ready_en, valid in SEND or COLLECT.
  - On in_valid && in_ready: result[rx_cnt] <= in_data, then rx_cnt++.
  - Results are stored in arrival order, unmodified, sign preserved.
  - in_valid while in_ready=0 is ignored (the accelerator holds its word).
- COLLECT: out_valid=0. When capture brings rx_cnt to N -> DONE.
- DONE: one cycle; done=1, busy=0 from the DONE cycle onward; -> IDLE.
- busy=1 in SEND and COLLECT only.
- cycle_count increments every SEND/COLLECT cycle, saturates at 16'hFFFF, and holds after done until the next accepted start.
- Boundaries:
  - start while busy or in DONE: ignored.
  - cfg_we while busy: ignored, so the buffer is locked during a run. cfg_we in IDLE/DONE writes on the clock edge.
  - cfg_addr >= TOTAL: write ignored.
  - Reset mid-run: immediate return to IDLE with all reset values; a subsequent start replays from tx_idx 0 using the retained buffer.
  - Extra in_valid beyond N results: not accepted, because in_ready=0.
  - res_addr >= N: res_data=0.

Test Plan:
- Identity: W=I, b={1,2,3}, x={10,20,30}, out_ready=1, in_ready_en=1 -> 15 bytes streamed in order 01,00,00,00,01,00,00,00,01,01,02,03,0A,14,1E on consecutive cycles; results 11,22,33; one done pulse; busy low after.
- Signed: W=all 8'hFF (-1), b=0, x={1,2,3} -> results 16'hFFFA x3 (-6); res_addr 0..2 read back -6.
- Source backpressure: out_ready toggled 1,0,1,0... -> exactly 15 transfers; out_data unchanged across every stall cycle; stream order identical to the identity case; cycle_count >= 29.
- Sink throttle: in_ready_en=0 for 5 cycles after the first in_valid -> in_ready=0, rx_cnt stays at 0; after release, results captured in order; done fires only after the third capture.
- Protocol abuse: start pulsed during SEND and cfg_we to addr 0 during COLLECT -> no restart, buffer[0] unchanged (verified on a rerun); in_valid asserted after 3 results -> not captured.
- Reset mid-SEND at tx_idx=7 -> next cycle out_valid=0, busy=0, counters 0; a new start re-streams from W[0] and produces correct results.
